pir_sensor_emulator: RTL

- Cycle-accurate behavioural model of the PIR motion sensor module that drives the pir_sensor line into the LED indicator logic; the transmitting end of that single-wire interface.
- Converts a raw motion stimulus into a PIR-style output with a power-on warm-up, a hold time, a post-hold blocking time, and selectable single/repeat trigger mode.
- Used on-chip for self-test and in benches as the stimulus source for the LED logic.

---
 rtl/pir_sensor_emulator_if.sv | 28 ++
 rtl/pir_sensor_emulator.sv | 94 +++++++++
 2 files changed

// File: rtl/pir_sensor_emulator_if.sv
// rtl/pir_sensor_emulator_if.sv - PIR emulator stimulus/output signal bundle
interface pir_sensor_emulator_if;
    logic       motion_in;
    logic       retrigger_en;
    logic       pir_out;
    logic       ready;
    logic [1:0] state_o;
    logic [7:0] trigger_count;

    // The emulator drives the PIR line; the consumer supplies motion stimulus.
    modport master (
        input  motion_in,
        input  retrigger_en,
        output pir_out,
        output ready,
        output state_o,
        output trigger_count
    );

    modport slave (
        output motion_in,
        output retrigger_en,
        input  pir_out,
        input  ready,
        input  state_o,
        input  trigger_count
    );
endinterface

// File: rtl/pir_sensor_emulator.sv
// rtl/pir_sensor_emulator.sv - PIR motion sensor model: warm-up, hold, block, retrigger
module pir_sensor_emulator #(
    parameter int WARMUP_CYCLES = 1000,
    parameter int HOLD_CYCLES   = 50,
    parameter int BLOCK_CYCLES  = 20,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pir_sensor_emulator_if.master  bus
);
    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2,
        S_BLOCK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLOCK_LAST = CNT_W'(BLOCK_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       trig_cnt, trig_cnt_nx;
    logic             ready_q, ready_nx;
    logic             pir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_WARMUP;
            cnt      <= '0;
            trig_cnt <= 8'd0;
            ready_q  <= 1'b0;
            pir_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            trig_cnt <= trig_cnt_nx;
            ready_q  <= ready_nx;
            // Registered from the next state so the line tracks ACTIVE with no input-to-output path.
            pir_q    <= (state_nx == S_ACTIVE);
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CNT_W'(1);
        trig_cnt_nx = trig_cnt;
        ready_nx    = ready_q;
        case (state)
            S_WARMUP: begin
                if (cnt == WARM_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    ready_nx = 1'b1;
                end
            end
            S_IDLE: begin
                cnt_nx = '0;
                if (bus.motion_in) begin
                    state_nx = S_ACTIVE;
                    if (trig_cnt != 8'hFF) begin
                        trig_cnt_nx = trig_cnt + 8'd1;
                    end
                end
            end
            S_ACTIVE: begin
                // A retrigger wins over expiry on the same edge.
                if (bus.retrigger_en && bus.motion_in) begin
                    cnt_nx = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = S_BLOCK;
                    cnt_nx   = '0;
                end
            end
            S_BLOCK: begin
                if (cnt == BLOCK_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_WARMUP;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.pir_out       = pir_q;
    assign bus.ready         = ready_q;
    assign bus.state_o       = state;
    assign bus.trigger_count = trig_cnt;
endmodule
